pad_share_arbiter: RTL and testbench

PAD_SHARE_ARBITER -- requirements
Module: pad_share_arbiter

---
 rtl/pad_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pad_share_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pad_share_arbiter.sv
// Round-robin owner arbiter for a shared pad group with a fixed released turnaround between owners.
// Optional owner hold timeout is enabled by defining PADARB_TIMEOUT_EN.
module pad_share_arbiter #(
  parameter int PAD_W    = 3,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [2:0]         req_i,
  input  logic [3*PAD_W-1:0] out_i,
  input  logic [3*PAD_W-1:0] oe_i,
  output logic [2:0]         gnt_o,
  output logic [PAD_W-1:0]   pad_out_o,
  output logic [PAD_W-1:0]   pad_oeb_o,
  input  logic [PAD_W-1:0]   pad_in_i,
  output logic [PAD_W-1:0]   in_o,
  output logic [1:0]         owner_o,
  output logic               revoked_o
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  localparam logic [3:0] TURN_LD = 4'(TURN_CYC);
  localparam logic [1:0] NO_OWNER = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [3:0] turn_q, turn_d;
  logic [1:0] pick;
  logic [2:0] own_oh;
  logic       own_req;
  logic       timeout;

  // Search last+1, last+2, last+3 (mod 3); the previous owner is tried last.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    int         s;
    rr_pick = NO_OWNER;
    for (int i = 3; i >= 1; i--) begin
      s   = int'(last) + i;
      idx = 2'(s % 3);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    to_onehot = 3'b001;
      2'd1:    to_onehot = 3'b010;
      2'd2:    to_onehot = 3'b100;
      default: to_onehot = 3'b000;
    endcase
  endfunction

  assign pick    = rr_pick(req_i, last_q);
  assign own_oh  = to_onehot(last_q);
  assign own_req = |(req_i & own_oh);

`ifdef PADARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD - 1);

  logic [15:0] hold_q, hold_d;
  logic        revoked_q, revoked_d;

  // Only a competing request can trigger a revoke; a lone owner just saturates.
  assign timeout = (hold_q == HOLD_LIM) && |(req_i & ~own_oh);

  always_comb begin
    hold_d    = 16'd0;
    revoked_d = 1'b0;
    if (state_q == OWN) begin
      hold_d    = (hold_q == HOLD_LIM) ? hold_q : hold_q + 16'd1;
      revoked_d = timeout && own_req;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= 16'd0;
      revoked_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      revoked_q <= revoked_d;
    end
  end

  assign revoked_o = revoked_q;
`else
  logic unused_max_hold;

  assign unused_max_hold = (MAX_HOLD > 0);
  assign timeout         = 1'b0;
  assign revoked_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      turn_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
    end
  end

  // last_q doubles as the owner index while in OWN.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (pick != NO_OWNER) begin
          state_d = OWN;
          last_d  = pick;
        end
      end
      OWN: begin
        if (!own_req || timeout) begin
          state_d = TURN;
          turn_d  = TURN_LD;
        end
      end
      TURN: begin
        if (turn_q <= 4'd1) begin
          turn_d = 4'd0;
          if (pick != NO_OWNER) begin
            state_d = OWN;
            last_d  = pick;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        turn_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    gnt_o     = 3'b000;
    owner_o   = NO_OWNER;
    pad_out_o = '0;
    pad_oeb_o = '1;
    if (state_q == OWN) begin
      gnt_o   = own_oh;
      owner_o = last_q;
      case (last_q)
        2'd0: begin
          pad_out_o = out_i[0*PAD_W +: PAD_W];
          pad_oeb_o = ~oe_i[0*PAD_W +: PAD_W];
        end
        2'd1: begin
          pad_out_o = out_i[1*PAD_W +: PAD_W];
          pad_oeb_o = ~oe_i[1*PAD_W +: PAD_W];
        end
        2'd2: begin
          pad_out_o = out_i[2*PAD_W +: PAD_W];
          pad_oeb_o = ~oe_i[2*PAD_W +: PAD_W];
        end
        default: begin
          pad_out_o = '0;
          pad_oeb_o = '1;
        end
      endcase
    end
  end

  assign in_o = pad_in_i;

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Directed bench for pad_share_arbiter: grant latency, turnaround, round-robin order, async reset, timeout.
module tb_pad_share_arbiter;
  localparam int PAD_W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         req;
  logic [3*PAD_W-1:0] out_v;
  logic [3*PAD_W-1:0] oe_v;
  logic [2:0]         gnt;
  logic [PAD_W-1:0]   pad_out;
  logic [PAD_W-1:0]   pad_oeb;
  logic [PAD_W-1:0]   pad_in;
  logic [PAD_W-1:0]   in_v;
  logic [1:0]         owner;
  logic               revoked;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pad_share_arbiter #(.PAD_W(PAD_W), .TURN_CYC(2), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .out_i(out_v), .oe_i(oe_v),
    .gnt_o(gnt), .pad_out_o(pad_out), .pad_oeb_o(pad_oeb), .pad_in_i(pad_in),
    .in_o(in_v), .owner_o(owner), .revoked_o(revoked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_released(input string tag);
    chk({tag, "_oeb"}, 32'(pad_oeb), 32'h7);
    chk({tag, "_out"}, 32'(pad_out), 32'h0);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_owner"}, 32'(owner), 32'h3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_own[4];

  initial begin
    // slices: GPIO out=001 oe=011, SPI out=101 oe=110, PWM out=110 oe=111
    out_v  = {3'b110, 3'b101, 3'b001};
    oe_v   = {3'b111, 3'b110, 3'b011};
    pad_in = 3'b010;
    rst_n  = 1'b0;
    req    = 3'b000;
    #2;
    chk_released("rst");
    chk("rst_revoked", 32'(revoked), 32'h0);
    chk("in_copy0", 32'(in_v), 32'h2);
    pad_in = 3'b101;
    #1;
    chk("in_copy1", 32'(in_v), 32'h5);
    do_reset();

    // single SPI request, one-cycle grant latency
    req = 3'b010;
    chk_released("pre_grant");
    step();
    chk("spi_gnt", 32'(gnt), 32'h2);
    chk("spi_owner", 32'(owner), 32'h1);
    chk("spi_out", 32'(pad_out), 32'h5);
    chk("spi_oeb", 32'(pad_oeb), 32'h1);
    out_v[1*PAD_W +: PAD_W] = 3'b011;
    #1;
    chk("spi_out_comb", 32'(pad_out), 32'h3);
    req = 3'b011;
    step();
    chk("spi_hold_gnt", 32'(gnt), 32'h2);

    // release turnaround: exactly two released cycles, then GPIO
    req = 3'b001;
    step();
    chk_released("turn1");
    step();
    chk_released("turn2");
    step();
    chk("gpio_gnt", 32'(gnt), 32'h1);
    chk("gpio_owner", 32'(owner), 32'h0);
    chk("gpio_out", 32'(pad_out), 32'h1);
    chk("gpio_oeb", 32'(pad_oeb), 32'h4);

    // release with nobody waiting ends in IDLE
    req = 3'b000;
    step();
    step();
    step();
    chk_released("idle_after_turn");
    step();
    chk_released("idle_stay");

    // simultaneous requests from reset: GPIO, SPI, PWM, GPIO
    do_reset();
    req = 3'b111;
    step();
    exp_own = '{2'd0, 2'd1, 2'd2, 2'd0};
    chk("rr_first", 32'(owner), 32'(exp_own[0]));
    for (int k = 1; k < 4; k++) begin
      req = 3'b111 & ~(3'b001 << exp_own[k-1]);
      step();
      chk("rr_turn_a", 32'(gnt), 32'h0);
      req = 3'b111;
      step();
      chk("rr_turn_b", 32'(gnt), 32'h0);
      step();
      chk("rr_owner", 32'(owner), 32'(exp_own[k]));
      chk("rr_gnt", 32'(gnt), 32'(3'b001 << exp_own[k]));
    end

    // asynchronous reset while PWM owns
    do_reset();
    req = 3'b100;
    step();
    chk("pwm_owner", 32'(owner), 32'h2);
    chk("pwm_oeb", 32'(pad_oeb), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_released("async_rst");
    rst_n = 1'b1;
    req   = 3'b000;
    step();

`ifdef PADARB_TIMEOUT_EN
    // GPIO held with SPI pending: revoke after 4 OWN cycles
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("to_own_gnt", 32'(gnt), 32'h1);
      chk("to_own_rev", 32'(revoked), 32'h0);
    end
    step();
    chk("to_revoke", 32'(revoked), 32'h1);
    chk("to_rev_gnt", 32'(gnt), 32'h0);
    step();
    chk("to_rev_pulse", 32'(revoked), 32'h0);
    chk_released("to_turn2");
    step();
    chk("to_spi_gnt", 32'(gnt), 32'h2);

    // lone requester is never revoked
    do_reset();
    req = 3'b001;
    for (int k = 0; k < 100; k++) begin
      step();
      chk("lone_gnt", 32'(gnt), 32'h1);
      chk("lone_rev", 32'(revoked), 32'h0);
    end
`else
    // no timeout: GPIO keeps the pads indefinitely despite SPI pending
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("nto_gnt", 32'(gnt), 32'h1);
      chk("nto_rev", 32'(revoked), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
